crypto1_key_rewind: RTL and testbench

- Sits directly downstream of the Crypto1 attack top-level.
- The attack recovers the 48-bit LFSR state REWIND clocks into the keystream. This block accepts that recovered state and steps the Crypto1 LFSR backwards one step per clock. It presents the original 48-bit key on a valid/ready output handshake.
- Also converts the attack's "search exhausted" indication into a sticky FAIL status.

---
 rtl/crypto1_key_rewind.sv | 97 +++++++++
 tb/tb_crypto1_key_rewind.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto1_key_rewind.sv
// Rewinds the Crypto1 LFSR state recovered by the attack back to the original 48-bit key.
// Optional CRYPTO1_REWIND_DYN_EN adds a per-key REWIND_STEPS input that replaces REWIND.
module crypto1_key_rewind #(
  parameter int          REWIND = 10,
  parameter logic [47:0] TAPS   = 48'h0E88_2B0A_D621
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [47:0] IN_KEY,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        SEARCH_DONE,
  output logic [47:0] OUT_KEY,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        BUSY,
  output logic        FAIL
`ifdef CRYPTO1_REWIND_DYN_EN
  ,
  input  logic [5:0]  REWIND_STEPS
`endif
);

  if (REWIND < 0 || REWIND > 63) begin : g_bad_rewind
    $error("crypto1_key_rewind: REWIND must be in 0..63");
  end
  if (TAPS[0] != 1'b1) begin : g_bad_taps
    $error("crypto1_key_rewind: TAPS bit 0 must be set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REWIND,
    S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [47:0] key_q;
  logic [5:0]  cnt_q;
  logic        fail_q;
  logic [5:0]  steps;
  logic        accept;

`ifdef CRYPTO1_REWIND_DYN_EN
  assign steps = REWIND_STEPS;
`else
  localparam logic [5:0] REWIND_C = 6'(REWIND);
  assign steps = REWIND_C;
`endif

  // Undo one forward step: the old bit 0 is recovered from the feedback bit now in bit 47.
  function automatic logic [47:0] inv_step(input logic [47:0] r);
    return {r[46:0], r[47] ^ (^(r[46:0] & TAPS[47:1]))};
  endfunction

  assign IN_READY  = (state_q == S_IDLE) && !RESET;
  assign OUT_VALID = (state_q == S_OUT);
  assign BUSY      = (state_q != S_IDLE);
  assign OUT_KEY   = key_q;
  assign FAIL      = fail_q;
  assign accept    = IN_VALID && IN_READY;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = (steps == 6'd0) ? S_OUT : S_REWIND;
      S_REWIND: if (cnt_q == 6'd1) state_d = S_OUT;
      S_OUT:    if (OUT_READY) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        key_q  <= IN_KEY;
        cnt_q  <= steps;
        fail_q <= 1'b0;
      end else if (state_q == S_IDLE) begin
        // SEARCH_DONE only counts while idle with no competing key.
        if (SEARCH_DONE) fail_q <= 1'b1;
      end else if (state_q == S_REWIND) begin
        key_q <= inv_step(key_q);
        cnt_q <= cnt_q - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_crypto1_key_rewind.sv
// Scoreboard bench for crypto1_key_rewind: one instance with REWIND=1, one with REWIND=10.
module tb_crypto1_key_rewind;

  localparam logic [47:0] TAPS = 48'h0E88_2B0A_D621;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [47:0] IN_KEY = '0;
  logic        SEARCH_DONE = 1'b0;
  logic        OUT_READY = 1'b0;
  logic        valid1 = 1'b0, valid10 = 1'b0;
  logic        rdy1, rdy10, ov1, ov10, busy1, busy10, fail1, fail10;
  logic [47:0] ok1, ok10;
`ifdef CRYPTO1_REWIND_DYN_EN
  logic [5:0]  rsteps = 6'd1;
`endif

  bit          sel = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [47:0] sb[$];

  logic        in_ready, out_valid, busy, fail;
  logic [47:0] out_key;

  always #5 CLK = ~CLK;

  crypto1_key_rewind #(.REWIND(1), .TAPS(TAPS)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .IN_KEY(IN_KEY), .IN_VALID(valid1), .IN_READY(rdy1),
    .SEARCH_DONE(SEARCH_DONE), .OUT_KEY(ok1), .OUT_VALID(ov1), .OUT_READY(OUT_READY),
    .BUSY(busy1), .FAIL(fail1)
`ifdef CRYPTO1_REWIND_DYN_EN
    , .REWIND_STEPS(rsteps)
`endif
  );

  crypto1_key_rewind #(.REWIND(10), .TAPS(TAPS)) u_dut10 (
    .CLK(CLK), .RESET(RESET), .IN_KEY(IN_KEY), .IN_VALID(valid10), .IN_READY(rdy10),
    .SEARCH_DONE(SEARCH_DONE), .OUT_KEY(ok10), .OUT_VALID(ov10), .OUT_READY(OUT_READY),
    .BUSY(busy10), .FAIL(fail10)
`ifdef CRYPTO1_REWIND_DYN_EN
    , .REWIND_STEPS(rsteps)
`endif
  );

  assign in_ready  = sel ? rdy10  : rdy1;
  assign out_valid = sel ? ov10   : ov1;
  assign busy      = sel ? busy10 : busy1;
  assign fail      = sel ? fail10 : fail1;
  assign out_key   = sel ? ok10   : ok1;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_valid(input logic v);
    if (sel) valid10 = v;
    else     valid1  = v;
  endtask

  function automatic int cur_steps();
`ifdef CRYPTO1_REWIND_DYN_EN
    return int'(rsteps);
`else
    return sel ? 10 : 1;
`endif
  endfunction

  // Forward reference model: rewinding must undo exactly n of these.
  function automatic logic [47:0] fwd(input logic [47:0] s, input int n);
    logic [47:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = {^(r & TAPS), r[47:1]};
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  // One full transaction: accept, wait for output, optional back-pressure, handshake.
  task automatic run_key(input logic [47:0] in_key, input logic [47:0] exp,
                         input int hold, input bit pulse);
    int          n;
    int          lat;
    logic [47:0] held;
    n = cur_steps();
    @(negedge CLK);
    check("in_ready_idle", 48'(in_ready), 48'd1);
    IN_KEY = in_key;
    drive_valid(1'b1);
    sb.push_back(exp);
    OUT_READY = (hold == 0);
    @(negedge CLK);
    SEARCH_DONE = 1'b0;
    drive_valid(1'b0);
    check("fail_clr_on_accept", 48'(fail), 48'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      check("busy_rewind", 48'(busy), 48'd1);
      check("in_ready_rewind", 48'(in_ready), 48'd0);
      if (pulse) begin
        IN_KEY = ~in_key;
        drive_valid(1'b1);
      end
      @(negedge CLK);
      lat++;
    end
    check("latency", 48'(lat), 48'(n + 1));
    if (!out_valid) begin
      void'(sb.pop_front());
      drive_valid(1'b0);
      OUT_READY = 1'b0;
      return;
    end
    held = out_key;
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        IN_KEY = ~in_key;
        drive_valid(1'b1);
      end
      @(negedge CLK);
      check("hold_valid", 48'(out_valid), 48'd1);
      check("hold_key", out_key, held);
      check("in_ready_out", 48'(in_ready), 48'd0);
    end
    drive_valid(1'b0);
    IN_KEY = in_key;
    OUT_READY = 1'b1;
    check("out_valid", 48'(out_valid), 48'd1);
    check("out_key", out_key, sb.pop_front());
    held = out_key;
    @(negedge CLK);
    OUT_READY = 1'b0;
    check("valid_drop", 48'(out_valid), 48'd0);
    check("in_ready_back", 48'(in_ready), 48'd1);
    check("busy_idle", 48'(busy), 48'd0);
    check("key_retain", out_key, held);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] orig;
    logic [47:0] kin;

    repeat (3) @(negedge CLK);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      check("rst_in_ready", 48'(in_ready), 48'd0);
      check("rst_out_valid", 48'(out_valid), 48'd0);
      check("rst_busy", 48'(busy), 48'd0);
      check("rst_fail", 48'(fail), 48'd0);
      check("rst_out_key", out_key, 48'd0);
    end
    RESET = 1'b0;
    @(negedge CLK);
    sel = 1'b0;
    check("in_ready_after_rst", 48'(in_ready), 48'd1);

    // REWIND=1 instance: directed single-step vectors plus one random.
`ifdef CRYPTO1_REWIND_DYN_EN
    rsteps = 6'd1;
`endif
    run_key(48'h8000_0000_0000, 48'h0000_0000_0001, 0, 1'b0);
    run_key(48'h0000_0000_0001, 48'h0000_0000_0002, 0, 1'b0);
    orig = rand48();
    run_key(fwd(orig, 1), orig, 2, 1'b1);

    // Sticky FAIL from SEARCH_DONE, cleared by the next accepted key.
    @(negedge CLK);
    SEARCH_DONE = 1'b1;
    @(negedge CLK);
    SEARCH_DONE = 1'b0;
    check("fail_set", 48'(fail), 48'd1);
    @(negedge CLK);
    check("fail_sticky", 48'(fail), 48'd1);
    check("fail_not_busy", 48'(busy), 48'd0);
    orig = rand48();
    run_key(fwd(orig, 1), orig, 0, 1'b0);
    check("fail_after_key", 48'(fail), 48'd0);
    SEARCH_DONE = 1'b1;
    orig = rand48();
    run_key(fwd(orig, 1), orig, 0, 1'b0);
    check("fail_simul_valid", 48'(fail), 48'd0);

    // REWIND=10 instance: reference key with back-pressure, then back-to-back randoms.
    sel = 1'b1;
`ifdef CRYPTO1_REWIND_DYN_EN
    rsteps = 6'd10;
`endif
    run_key(fwd(48'h27568D75631F, 10), 48'h27568D75631F, 5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      orig = rand48();
      run_key(fwd(orig, 10), orig, i, 1'b0);
    end

    // Asynchronous reset with the counter at 4, then a clean transaction.
    orig = rand48();
    kin = fwd(orig, 10);
    @(negedge CLK);
    IN_KEY = kin;
    drive_valid(1'b1);
    @(negedge CLK);
    drive_valid(1'b0);
    repeat (6) @(negedge CLK);
    check("busy_pre_rst", 48'(busy), 48'd1);
    #2 RESET = 1'b1;
    #1;
    check("arst_out_valid", 48'(out_valid), 48'd0);
    check("arst_busy", 48'(busy), 48'd0);
    check("arst_fail", 48'(fail), 48'd0);
    check("arst_out_key", out_key, 48'd0);
    check("arst_in_ready", 48'(in_ready), 48'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("in_ready_rerelease", 48'(in_ready), 48'd1);
    check("no_partial_out", 48'(out_valid), 48'd0);
    run_key(kin, orig, 0, 1'b0);

`ifdef CRYPTO1_REWIND_DYN_EN
    rsteps = 6'd0;
    run_key(48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 0, 1'b0);
    rsteps = 6'd63;
    orig = rand48();
    run_key(fwd(orig, 63), orig, 1, 1'b0);
`endif

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
